pc_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the uniprocessor front end. Owns the program counter and
//  the instruction-memory request. Decides each cycle between sequential +4,

---
 rtl/pc_fetch_ctrl_if.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request bus between the fetch sequencer and imem.
// Master issues pc_addr/ce; slave answers with imem_ready/imem_rdata.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);

    logic [ADDR_W-1:0] pc_addr;
    logic              ce;
    logic              imem_ready;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output pc_addr,
        output ce,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  pc_addr,
        input  ce,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem requests and holds one
// fetched instruction for decode in a single-entry output register.
module pc_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              trap_req,
    pc_fetch_ctrl_if.master   imem,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_HALT
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] if_pc_q;
    logic [ADDR_W-1:0] if_pc_d;
    logic [INST_W-1:0] if_inst_q;
    logic [INST_W-1:0] if_inst_d;
    logic              if_valid_q;
    logic              if_valid_d;
    logic              misalign_q;
    logic              misalign_d;

    logic              ce;
    logic              beat;
    logic              consume;
    logic              flush;
    logic              misalign;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;

    // Request/handshake qualifiers and redirect target selection.
    always_comb begin
        ce       = (state_q == ST_FETCH) && !(if_valid_q && stall);
        beat     = ce && imem.imem_ready;
        consume  = if_valid_q && !stall;
        flush    = trap_req || redirect_valid;
        misalign = redirect_valid && !trap_req
                 && (redirect_pc[1:0] != 2'b00);
        pc_inc   = pc_q + ADDR_W'(4);
        target   = redirect_pc;
        if (trap_req || misalign) begin
            target = TRAP_VEC;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        misalign_d = misalign;

        if (flush) begin
            // A beat landing with a redirect is dropped with the flush.
            pc_d       = target;
            if_valid_d = 1'b0;
            state_d    = halt ? ST_HALT : ST_FETCH;
        end else begin
            if (beat) begin
                if_inst_d  = imem.imem_rdata;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_inc;
            end else if (consume) begin
                if_valid_d = 1'b0;
            end

            unique case (state_q)
                ST_BOOT: begin
                    state_d = halt ? ST_HALT : ST_FETCH;
                end
                ST_FETCH: begin
                    if (halt && !beat && (!if_valid_q || consume)) begin
                        state_d = ST_HALT;
                    end else if (if_valid_q && stall) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_d = halt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_BOOT;
            pc_q       <= BOOT_ADDR;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.pc_addr = pc_q;
    assign imem.ce      = ce;
    assign if_valid     = if_valid_q;
    assign if_inst      = if_inst_q;
    assign if_pc        = if_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; imem returns pc ^ 32'hC0DE_0000
// so every expected instruction word is a fixed hex constant.
module tb_pc_fetch_ctrl;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_req;
    logic        rdy;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        misalign_err;

    int n_chk = 0;
    int n_bad = 0;

    pc_fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = bus.pc_addr ^ 32'hC0DE_0000;

    pc_fetch_ctrl dut (
        .sys_clk        (sys_clk),
        .rstn           (rstn),
        .stall          (stall),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_req       (trap_req),
        .imem           (bus),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    logic [31:0] seq_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] seq_inst [4] = '{32'hC0DE_0000, 32'hC0DE_0004,
                                  32'hC0DE_0008, 32'hC0DE_000C};

    initial begin
        rstn           = 1'b0;
        stall          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap_req       = 1'b0;
        rdy            = 1'b0;
        #2;
        check("rst_ce",    {31'b0, bus.ce}, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_pc",    bus.pc_addr, 32'h0);
        check("rst_inst",  if_inst, 32'h0);
        check("rst_ifpc",  if_pc, 32'h0);
        check("rst_mis",   {31'b0, misalign_err}, 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check("boot_ce", {31'b0, bus.ce}, 32'h0);
        tick();
        check("fetch_ce", {31'b0, bus.ce}, 32'h1);
        check("fetch_pc", bus.pc_addr, 32'h0);

        // back-to-back fetch
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq_valid", {31'b0, if_valid}, 32'h1);
            check("seq_ifpc", if_pc, seq_pc[i]);
            check("seq_inst", if_inst, seq_inst[i]);
        end
        check("seq_pc", bus.pc_addr, 32'h10);

        // stall with a full slot
        stall = 1'b1;
        #1;
        check("stall_ce0", {31'b0, bus.ce}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ifpc", if_pc, 32'hC);
            check("stall_inst", if_inst, 32'hC0DE_000C);
            check("stall_pc", bus.pc_addr, 32'h10);
            check("stall_ce", {31'b0, bus.ce}, 32'h0);
            check("stall_valid", {31'b0, if_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check("unstall_valid", {31'b0, if_valid}, 32'h0);
        check("unstall_ce", {31'b0, bus.ce}, 32'h1);
        tick();
        check("resume_ifpc", if_pc, 32'h10);
        check("resume_inst", if_inst, 32'hC0DE_0010);
        check("resume_pc", bus.pc_addr, 32'h14);

        // redirect colliding with a beat
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid", {31'b0, if_valid}, 32'h0);
        check("redir_pc", bus.pc_addr, 32'h40);
        tick();
        check("redir_ifpc", if_pc, 32'h40);
        check("redir_inst", if_inst, 32'hC0DE_0040);

        // misaligned redirect, then trap beating redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("mis_err", {31'b0, misalign_err}, 32'h1);
        check("mis_pc", bus.pc_addr, 32'h100);
        check("mis_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check("mis_pulse", {31'b0, misalign_err}, 32'h0);
        check("mis_ifpc", if_pc, 32'h100);
        redirect_valid = 1'b1;
        trap_req       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        trap_req       = 1'b0;
        check("trap_pc", bus.pc_addr, 32'h100);
        check("trap_err", {31'b0, misalign_err}, 32'h0);
        check("trap_valid", {31'b0, if_valid}, 32'h0);

        // wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_pre", bus.pc_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", bus.pc_addr, 32'h0);
        check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
        check("wrap_inst", if_inst, 32'h3F21_FFFC);

        // halt once the slot drains
        rdy  = 1'b0;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_ce", {31'b0, bus.ce}, 32'h0);
            check("halt_valid", {31'b0, if_valid}, 32'h0);
            check("halt_pc", bus.pc_addr, 32'h0);
        end
        halt = 1'b0;
        rdy  = 1'b1;
        tick();
        check("unhalt_ce", {31'b0, bus.ce}, 32'h1);
        tick();
        check("unhalt_ifpc", if_pc, 32'h0);
        check("unhalt_inst", if_inst, 32'hC0DE_0000);
        check("unhalt_pc", bus.pc_addr, 32'h4);

        // asynchronous reset while fetching
        #2;
        check("pre_rst_ce", {31'b0, bus.ce}, 32'h1);
        rstn = 1'b0;
        #1;
        check("arst_ce", {31'b0, bus.ce}, 32'h0);
        check("arst_valid", {31'b0, if_valid}, 32'h0);
        check("arst_pc", bus.pc_addr, 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        check("arst_boot_ce", {31'b0, bus.ce}, 32'h0);
        tick();
        check("arst_fetch_ce", {31'b0, bus.ce}, 32'h1);
        check("arst_fetch_pc", bus.pc_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
